// File: rtl/bgp_io_pkg.sv
// Shared types and constants for the bandgap IO controller: FSM states,
// register word offsets, CTRL bit positions and the byte-select merge helper.
package bgp_io_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_READY  = 2'd2
    } state_e;

    localparam logic [3:0] OFS_CTRL   = 4'd0;
    localparam logic [3:0] OFS_STATUS = 4'd1;
    localparam logic [3:0] OFS_SETTLE = 4'd2;
    localparam logic [3:0] OFS_OUT_LO = 4'd3;
    localparam logic [3:0] OFS_OUT_HI = 4'd4;
    localparam logic [3:0] OFS_OEB_LO = 4'd5;
    localparam logic [3:0] OFS_OEB_HI = 4'd6;
    localparam logic [3:0] OFS_IN_LO  = 4'd7;
    localparam logic [3:0] OFS_IN_HI  = 4'd8;
    localparam logic [3:0] OFS_IRQ    = 4'd9;

    localparam int unsigned CTRL_EN = 0;
    localparam int unsigned CTRL_IE = 1;

    // Merge a Wishbone write into the current word, one byte lane per select bit.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/bgp_io_ctrl_settle_fsm.sv
// Bandgap settle sequencer: enables the bandgap, waits the programmed number
// of cycles, then reports ready. done_pulse marks the cycle that enters READY.
module bgp_settle_fsm
    import bgp_io_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] settle_val,
    output logic        bgp_en,
    output logic        ready,
    output logic        done_pulse,
    output logic [1:0]  state
);

    state_e      st_q;
    logic [15:0] cnt_q;

    // A load of N spends max(N,1) cycles in SETTLE before READY.
    assign done_pulse = (st_q == ST_SETTLE) && en && (cnt_q <= 16'd1);
    assign state      = st_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_OFF;
            cnt_q  <= 16'd0;
            bgp_en <= 1'b0;
            ready  <= 1'b0;
        end else begin
            case (st_q)
                ST_OFF: begin
                    if (en) begin
                        st_q   <= ST_SETTLE;
                        cnt_q  <= settle_val;
                        bgp_en <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!en) begin
                        st_q   <= ST_OFF;
                        bgp_en <= 1'b0;
                    end else if (cnt_q <= 16'd1) begin
                        st_q  <= ST_READY;
                        ready <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_READY: begin
                    if (!en) begin
                        st_q   <= ST_OFF;
                        bgp_en <= 1'b0;
                        ready  <= 1'b0;
                    end
                end
                default: begin
                    st_q   <= ST_OFF;
                    bgp_en <= 1'b0;
                    ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bgp_io_ctrl.sv
// Wishbone-mapped GPIO bank and bandgap settle manager for the bandgap user
// project; analog pads named in ANA_MASK are held high-Z.
module bgp_io_ctrl
    import bgp_io_pkg::*;
#(
    parameter int unsigned NUM_IO     = 38,
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter logic [63:0] ANA_MASK   = 64'h0,
    parameter logic [15:0] SETTLE_RST = 16'd1000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic              bgp_en_o,
    output logic              bgp_ready_o,
    output logic              irq_o
);

    localparam logic [63:0] IO_MASK = (NUM_IO >= 64) ? {64{1'b1}}
                                                     : ((64'd1 << NUM_IO) - 64'd1);

    logic [1:0]        ctrl_q;
    logic [15:0]       settle_q;
    logic [63:0]       out_q;
    logic [63:0]       oeb_q;
    logic [NUM_IO-1:0] sync1_q;
    logic [NUM_IO-1:0] sync2_q;
    logic              pending_q;

    logic        hit;
    logic        access;
    logic        wr;
    logic [3:0]  ofs;
    logic [31:0] rdata;
    logic [31:0] wr_word;
    logic [63:0] in64;
    logic [1:0]  fsm_state;
    logic        done_pulse;
    logic        unused_adr;

    assign unused_adr = &{1'b0, wbs_adr_i[7:6], wbs_adr_i[1:0]};

    // One ack per hit, never back-to-back, so a held strobe acks every other cycle.
    assign hit    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign access = hit & ~wbs_ack_o;
    assign wr     = access & wbs_we_i;
    assign ofs    = wbs_adr_i[5:2];
    assign in64   = 64'(sync2_q);

    always_comb begin
        rdata = 32'd0;
        case (ofs)
            OFS_CTRL:   rdata = 32'(ctrl_q);
            OFS_STATUS: rdata = 32'({bgp_ready_o, fsm_state});
            OFS_SETTLE: rdata = 32'(settle_q);
            OFS_OUT_LO: rdata = out_q[31:0];
            OFS_OUT_HI: rdata = out_q[63:32];
            OFS_OEB_LO: rdata = oeb_q[31:0];
            OFS_OEB_HI: rdata = oeb_q[63:32];
            OFS_IN_LO:  rdata = in64[31:0];
            OFS_IN_HI:  rdata = in64[63:32];
            OFS_IRQ:    rdata = 32'(pending_q);
            default:    rdata = 32'd0;
        endcase
    end

    // Readback of the writable registers doubles as the old value for byte merging.
    assign wr_word = apply_sel(rdata, wbs_dat_i, wbs_sel_i);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            ctrl_q    <= 2'd0;
            settle_q  <= SETTLE_RST;
            out_q     <= 64'd0;
            oeb_q     <= IO_MASK;
            pending_q <= 1'b0;
            irq_o     <= 1'b0;
            io_out    <= '0;
            io_oeb    <= '1;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= access ? rdata : 32'd0;

            if (wr) begin
                case (ofs)
                    OFS_CTRL:   ctrl_q   <= wr_word[1:0];
                    OFS_SETTLE: settle_q <= wr_word[15:0];
                    OFS_OUT_LO: out_q    <= {out_q[63:32], wr_word} & IO_MASK;
                    OFS_OUT_HI: out_q    <= {wr_word, out_q[31:0]} & IO_MASK;
                    OFS_OEB_LO: oeb_q    <= {oeb_q[63:32], wr_word} & IO_MASK;
                    OFS_OEB_HI: oeb_q    <= {wr_word, oeb_q[31:0]} & IO_MASK;
                    default: ;
                endcase
            end

            // Completion beats a same-cycle write-1-to-clear.
            if (done_pulse) begin
                pending_q <= 1'b1;
            end else if (wr && (ofs == OFS_IRQ) && wbs_sel_i[0] && wbs_dat_i[0]) begin
                pending_q <= 1'b0;
            end

            irq_o   <= pending_q & ctrl_q[CTRL_IE];
            io_out  <= NUM_IO'(out_q & ~ANA_MASK);
            io_oeb  <= NUM_IO'(oeb_q | ANA_MASK);
            sync1_q <= io_in;
            sync2_q <= sync1_q;
        end
    end

    bgp_settle_fsm u_settle_fsm (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .en         (ctrl_q[CTRL_EN]),
        .settle_val (settle_q),
        .bgp_en     (bgp_en_o),
        .ready      (bgp_ready_o),
        .done_pulse (done_pulse),
        .state      (fsm_state)
    );

endmodule

// File: doc/bgp_io_ctrl.md
Name: bgp_io_ctrl

Overview:
Parametrised Wishbone-controlled manager for the bandgap user project, instantiated inside user_project_wrapper next to the analog macro. It generalises the direct pad pass-through to a register-mapped GPIO bank of NUM_IO pads. Pads listed in a per-pad analog mask are forced to high-Z. A settle sequencer enables the bandgap, counts a programmable settle time, then asserts ready and a maskable interrupt.

Parameters:
NUM_IO, 38, number of managed pads (1..64)
BASE_ADR, 32'h3000_0000, Wishbone base; decode on wbs_adr_i[31:8] == BASE_ADR[31:8]
ANA_MASK, 64'h0, bit i = 1: pad i is analog, io_oeb[i] forced 1 and io_out[i] forced 0
SETTLE_RST, 16'd1000, reset value of the SETTLE register (cycles)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous, active-high reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
io_in  in  NUM_IO  pad inputs (asynchronous)
io_out  out  NUM_IO  pad outputs
io_oeb  out  NUM_IO  pad output-enable, active low
bgp_en_o  out  1  bandgap enable to the analog macro
bgp_ready_o  out  1  settle complete
irq_o  out  1  to user_irq[0]

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high. All state is cleared on the wb_clk_i edge where wb_rst_i=1.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, io_out=0, io_oeb=all 1, bgp_en_o=0, bgp_ready_o=0, irq_o=0, CTRL=0, SETTLE=SETTLE_RST, IRQ pending=0, FSM=OFF.
- Wishbone handshake:
  - A hit is stb&cyc&decode match.
  - wbs_ack_o is asserted for exactly one cycle, in the cycle after the hit is sampled.
  - No ack is issued in the cycle following an ack, so a held strobe gets one ack every 2 cycles.
  - A miss produces no ack.
  - Writes honour wbs_sel_i per byte.
  - wbs_dat_o is valid during ack, and is 0 otherwise.
  - Unused or unmapped bits read 0.
- Register map (word offset = adr[5:2]):
  - 0 CTRL: [0] EN, [1] IE
  - 1 STATUS (RO): [1:0] state, [2] ready
  - 2 SETTLE: [15:0]
  - 3 OUT_LO, 4 OUT_HI
  - 5 OEB_LO, 6 OEB_HI (reset all 1)
  - 7 IN_LO, 8 IN_HI (RO)
  - 9 IRQ: [0] pending; writing 1 clears it
  - Offsets 10-15 ack and read 0, and writes to them are ignored.
  - _HI registers cover pads 32..NUM_IO-1.
- Pad outputs: io_out[i] = OUT[i] & ~ANA_MASK[i]; io_oeb[i] = OEB[i] | ANA_MASK[i]. Both are registered, so a write becomes visible on the pads the cycle after its ack.
- IN registers: io_in passes through a 2-flop synchroniser, so a pad change becomes readable 2 cycles after it is sampled.
- FSM states: OFF=0, SETTLE=1, READY=2.
  - OFF: bgp_en_o=0. When EN=1, move to SETTLE and load cnt=SETTLE.
  - SETTLE: bgp_en_o=1, cnt decrements each cycle. When cnt==0, move to READY and set pending. A write to CTRL that sets EN at edge T therefore reaches READY at edge T+1+SETTLE. SETTLE=0 gives READY after one cycle in SETTLE.
  - READY: bgp_en_o=1, bgp_ready_o=1. When EN=0, move to OFF.
  - EN cleared during SETTLE: move to OFF, pending is not set.
  - SETTLE written mid-run: affects only the next run.
- Interrupt: irq_o = pending & IE, registered.
- Simultaneous set and clear of pending (W1C in the same cycle as SETTLE→READY): set wins.
- Reset mid-operation: everything returns to reset values in the next cycle, including a pending ack.

Decomposition:
- Package bgp_io_pkg holds the state enum (OFF/SETTLE/READY), the register offset constants, and the CTRL bit indices.
- One sub-module, bgp_settle_fsm: FSM plus the 16-bit down-counter. Inputs are en and settle_val; outputs are bgp_en, ready and done_pulse.
- Register file, decode and pad logic stay in the top module.

Test Plan:
- Reset → io_oeb=all 1, io_out=0, SETTLE reads 1000, STATUS=0, irq_o=0.
- Write SETTLE=4, then CTRL=3 (EN, IE) → bgp_en_o rises the cycle after the ack; bgp_ready_o and STATUS=0x6 at ack edge+5; irq_o follows one cycle later. Write IRQ=1 → irq_o drops the next cycle.
- ANA_MASK=64'h1, write OUT_LO=0xFFFFFFFF and OEB_LO=0 → io_out[0]=0 and io_oeb[0]=1; pads 1..31 give io_out=1 and io_oeb=0.
- Write OUT_LO=0x12345678 with sel=4'b0010 → readback 0x00005600.
- Write SETTLE=100, then CTRL=1, then CTRL=0 after 10 cycles → state OFF, pending=0, bgp_ready_o never asserted.
- Toggle io_in[5] → IN_LO bit 5 changes 2 cycles later. Read offset 12 → ack with data 0. Address outside the base → no ack.
